nvdla_ram_fifo_ctrl: RTL and testbench
======================================

NVDLA_RAM_FIFO_CTRL -- requirements
Module: nvdla_ram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be none; depth fixed at 32 entries, data width fixed at 256 bits.
REQ-002 nvdla_core_clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-003 nvdla_core_rstn  in  1  reset, asynchronous, active-low.
REQ-004 wr_pvld  in  1  write-side data valid.
REQ-005 wr_prdy  out  1  write-side ready.
REQ-006 wr_pd  in  256  write data.
REQ-007 rd_pvld  out  1  read-side data valid.
REQ-008 rd_prdy  in  1  read-side ready.
REQ-009 rd_pd  out  256  read data.
REQ-010 ram_we / ram_wa / ram_di  out  1/5/256  RAM write port controls.
REQ-011 ram_re / ram_ra  out  1/5  RAM read port; RAM registers ram_ra on ram_re, ram_dout valid the following cycle.
REQ-012 ram_dout  in  256  RAM read data.
REQ-013 pwrbus_ram_pd  in  32  power bus, SHALL be forwarded unchanged on ram_pwrbus_pd (out, 32).
REQ-014 fifo_count  out  6  total occupancy (RAM + in-flight + output buffer), 0..34.
REQ-015 idle  out  1  fifo_count==0 and !wr_pvld.

Function
REQ-016 push = wr_pvld & wr_prdy; pop = rd_pvld & rd_prdy.
REQ-017 wr_prdy SHALL equal (ram_cnt != 32) from registered ram_cnt only; no same-cycle credit from a read.
REQ-018 On push: ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd; wr_ptr (5 bit) increments, 31 wraps to 0.
REQ-019 ram_cnt (6 bit) SHALL update as ram_cnt + push - ram_re each cycle.
REQ-020 State: ob_cnt (0..2, output buffer entries), inflight (1 bit, ram_re registered).
REQ-021 ram_re SHALL be (ram_cnt != 0) & (ob_cnt + inflight - pop < 2); ram_ra = rd_ptr; rd_ptr increments on ram_re, wraps 31 to 0.
REQ-022 When inflight=1, ram_dout SHALL be written into the output buffer at the tail in the same edge; order strictly FIFO.
REQ-023 rd_pvld = (ob_cnt != 0); rd_pd = head of output buffer, driven from registers only; no combinational path from wr_pd or ram_dout.
REQ-024 Simultaneous capture and pop SHALL leave ob_cnt unchanged and shift correctly; buffer overflow impossible by REQ-021.
REQ-025 Latency: push in cycle 0 -> ram_re cycle 1 -> capture end of cycle 2 -> rd_pvld=1 in cycle 3 (empty FIFO).
REQ-026 Throughput: with rd_prdy=1 and data available, one pop per cycle sustained.
REQ-027 Push while ram_cnt==0 SHALL NOT produce ram_re that cycle (read only after count visible).
REQ-028 rd_pd SHALL hold stable while rd_pvld=1 and rd_prdy=0.
REQ-029 fifo_count = ram_cnt + inflight + ob_cnt, combinational from registers.

Reset
REQ-030 On nvdla_core_rstn low: wr_ptr, rd_ptr, ram_cnt, inflight, ob_cnt, buffer data = 0; wr_prdy=1, rd_pvld=0, rd_pd=0, ram_we=0, ram_re=0, fifo_count=0.
REQ-031 Reset mid-operation SHALL discard all queued and in-flight data; RAM contents not cleared, never read before rewritten.

Verification
REQ-032 Single push 0xA5..A5 into empty FIFO, rd_prdy=1 -> ram_re cycle 1, rd_pvld cycle 3 with rd_pd=0xA5..A5, fifo_count returns to 0.
REQ-033 34 pushes with rd_prdy=0 -> wr_prdy=0 after 34th push, fifo_count=34, ram_cnt=32, ob_cnt=2; one pop -> wr_prdy=1 next cycle.
REQ-034 Streaming 100 incrementing words with rd_prdy=1 -> output in order, one per cycle after first, pointers wrap 31->0 without loss.
REQ-035 Random rd_prdy backpressure over 1000 words -> no loss/duplication, rd_pd stable while stalled, fifo_count never > 34.
REQ-036 Assert nvdla_core_rstn low with fifo_count=10 and inflight=1 -> all outputs per REQ-030 immediately; after release, new push 0x1 is first word read.

Source files
------------

// File: rtl/nvdla_ram_fifo_ctrl.sv
// 32-entry x 256-bit FIFO controller in front of an external two-port RAM with
// a one-cycle registered read, plus a two-entry output buffer for full-rate draining.
module nvdla_ram_fifo_ctrl (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [255:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [255:0] rd_pd,
  output logic         ram_we,
  output logic [4:0]   ram_wa,
  output logic [255:0] ram_di,
  output logic         ram_re,
  output logic [4:0]   ram_ra,
  input  logic [255:0] ram_dout,
  input  logic [31:0]  pwrbus_ram_pd,
  output logic [31:0]  ram_pwrbus_pd,
  output logic [5:0]   fifo_count,
  output logic         idle
);

  logic [4:0]   wr_ptr;
  logic [4:0]   rd_ptr;
  logic [5:0]   ram_cnt;
  logic         inflight;
  logic [1:0]   ob_cnt;
  logic [255:0] ob_head;
  logic [255:0] ob_tail;

  logic         push;
  logic         pop;
  logic [2:0]   ob_claim;
  logic [1:0]   ob_base;

  assign wr_prdy  = (ram_cnt != 6'd32);
  assign push     = wr_pvld & wr_prdy;
  assign rd_pvld  = (ob_cnt != 2'd0);
  assign pop      = rd_pvld & rd_prdy;

  // A RAM read is only launched when the output buffer is guaranteed a free
  // slot on the capture edge, counting the word already in flight.
  assign ob_claim = {1'b0, ob_cnt} + {2'b00, inflight};
  assign ram_re   = (ram_cnt != 6'd0) & (ob_claim < (3'd2 + {2'b00, pop}));
  assign ram_ra   = rd_ptr;

  assign ram_we   = push;
  assign ram_wa   = wr_ptr;
  assign ram_di   = wr_pd;

  assign rd_pd         = ob_head;
  assign ram_pwrbus_pd = pwrbus_ram_pd;
  assign fifo_count    = ram_cnt + {5'b00000, inflight} + {4'b0000, ob_cnt};
  assign idle          = (fifo_count == 6'd0) & ~wr_pvld;

  // Slot the captured word lands in, after any shift caused by this cycle's pop.
  assign ob_base  = ob_cnt - {1'b0, pop};

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr   <= 5'd0;
      rd_ptr   <= 5'd0;
      ram_cnt  <= 6'd0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 5'd1;
      end
      if (ram_re) begin
        rd_ptr <= rd_ptr + 5'd1;
      end
      ram_cnt  <= ram_cnt + {5'b00000, push} - {5'b00000, ram_re};
      inflight <= ram_re;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ob_cnt  <= 2'd0;
      ob_head <= '0;
      ob_tail <= '0;
    end else begin
      ob_cnt <= ob_cnt + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        ob_head <= ob_tail;
      end
      if (inflight) begin
        if (ob_base == 2'd0) begin
          ob_head <= ram_dout;
        end else begin
          ob_tail <= ram_dout;
        end
      end
    end
  end

  a_ob_bound: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    ob_cnt <= 2'd2);
  a_ram_bound: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    ram_cnt <= 6'd32);
  a_no_overflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(inflight && !pop && ob_cnt == 2'd2));

endmodule

// File: tb/tb_nvdla_ram_fifo_ctrl.sv
// Scoreboard bench for nvdla_ram_fifo_ctrl with a behavioural registered-read RAM.
`timescale 1ns/1ps
module tb_nvdla_ram_fifo_ctrl;

  logic         clk;
  logic         rstn;
  logic         wr_pvld;
  logic         wr_prdy;
  logic [255:0] wr_pd;
  logic         rd_pvld;
  logic         rd_prdy;
  logic [255:0] rd_pd;
  logic         ram_we;
  logic [4:0]   ram_wa;
  logic [255:0] ram_di;
  logic         ram_re;
  logic [4:0]   ram_ra;
  logic [255:0] ram_dout;
  logic [31:0]  pwrbus_ram_pd;
  logic [31:0]  ram_pwrbus_pd;
  logic [5:0]   fifo_count;
  logic         idle;

  logic [255:0] mem [32];
  logic [255:0] exp_q [$];
  int checks;
  int errors;
  int pops_total;

  nvdla_ram_fifo_ctrl dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .ram_we         (ram_we),
    .ram_wa         (ram_wa),
    .ram_di         (ram_di),
    .ram_re         (ram_re),
    .ram_ra         (ram_ra),
    .ram_dout       (ram_dout),
    .pwrbus_ram_pd  (pwrbus_ram_pd),
    .ram_pwrbus_pd  (ram_pwrbus_pd),
    .fifo_count     (fifo_count),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM: address captured on ram_re, data valid next cycle.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  // Scoreboard monitor: occupancy, in-order data and stall stability.
  initial begin
    logic         stalled;
    logic [255:0] held_pd;
    logic [255:0] exp_word;
    stalled = 1'b0;
    held_pd = '0;
    pops_total = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled = 1'b0;
      end else begin
        checks++;
        if (int'(fifo_count) !== exp_q.size()) begin
          errors++;
          $display("[TB] FAIL sb_count: fifo_count=%0d expected %0d", fifo_count, exp_q.size());
        end
        if (stalled) begin
          checks++;
          if (rd_pvld !== 1'b1 || rd_pd !== held_pd) begin
            errors++;
            $display("[TB] FAIL sb_stall_hold: rd_pvld=%b rd_pd=%h expected 1 / %h", rd_pvld, rd_pd, held_pd);
          end
        end
        if (rd_pvld && rd_prdy) begin
          checks++;
          pops_total++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_pop_empty: got %h expected no output", rd_pd);
          end else begin
            exp_word = exp_q.pop_front();
            if (rd_pd !== exp_word) begin
              errors++;
              $display("[TB] FAIL sb_data: got %h expected %h", rd_pd, exp_word);
            end
          end
        end
        if (wr_pvld && wr_prdy) exp_q.push_back(wr_pd);
        stalled = rd_pvld && !rd_prdy;
        held_pd = rd_pd;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0; pwrbus_ram_pd = 32'hDEADBEEF;
    repeat (3) tick();
    #1;
    checks++; if (wr_prdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_prdy: got %b expected 1", wr_prdy); end
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_pvld: got %b expected 0", rd_pvld); end
    checks++; if (rd_pd !== 256'd0) begin errors++; $display("[TB] FAIL reset_rd_pd: got %h expected 0", rd_pd); end
    checks++; if (ram_re !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_ctl: got re=%b we=%b expected 0/0", ram_re, ram_we); end
    checks++; if (fifo_count !== 6'd0 || idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_count: got %0d idle=%b expected 0 idle=1", fifo_count, idle); end
    checks++; if (ram_pwrbus_pd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL pwrbus: got %h expected deadbeef", ram_pwrbus_pd); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    logic [255:0] word;
    word = {32{8'hA5}};
    tick(); wr_pvld = 1'b1; wr_pd = word; rd_prdy = 1'b1; #1;
    checks++; if (ram_we !== 1'b1 || ram_wa !== 5'd0 || ram_di !== word) begin errors++; $display("[TB] FAIL single_write: got we=%b wa=%0d di=%h expected 1/0/%h", ram_we, ram_wa, ram_di, word); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("[TB] FAIL single_no_early_re: got %b expected 0", ram_re); end
    tick(); wr_pvld = 1'b0; wr_pd = '0; #1;
    checks++; if (ram_re !== 1'b1 || ram_ra !== 5'd0) begin errors++; $display("[TB] FAIL single_re_c1: got re=%b ra=%0d expected 1/0", ram_re, ram_ra); end
    tick(); #1;
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("[TB] FAIL single_pvld_c2: got %b expected 0", rd_pvld); end
    tick(); #1;
    checks++; if (rd_pvld !== 1'b1 || rd_pd !== word) begin errors++; $display("[TB] FAIL single_out_c3: got pvld=%b pd=%h expected 1/%h", rd_pvld, rd_pd, word); end
    tick(); #1;
    checks++; if (fifo_count !== 6'd0 || idle !== 1'b1) begin errors++; $display("[TB] FAIL single_drained: got count=%0d idle=%b expected 0/1", fifo_count, idle); end
  endtask

  task automatic test_fill();
    int n;
    int guard;
    n = 0; guard = 0;
    rd_prdy = 1'b0;
    while (n < 34 && guard < 200) begin
      tick(); wr_pvld = 1'b1; wr_pd = 256'(n + 'h1000); #1;
      if (wr_prdy) n++;
      guard++;
    end
    checks++; if (n != 34) begin errors++; $display("[TB] FAIL fill_pushes: got %0d expected 34", n); end
    tick(); wr_pvld = 1'b1; wr_pd = 256'h0BAD; #1;
    checks++; if (wr_prdy !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: got prdy=%b we=%b expected 0/0", wr_prdy, ram_we); end
    checks++; if (fifo_count !== 6'd34) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 34", fifo_count); end
    tick(); wr_pvld = 1'b0; rd_prdy = 1'b1; #1;
    checks++; if (ram_re !== 1'b1) begin errors++; $display("[TB] FAIL fill_pop_re: got %b expected 1", ram_re); end
    tick(); rd_prdy = 1'b0; #1;
    checks++; if (wr_prdy !== 1'b1 || fifo_count !== 6'd33) begin errors++; $display("[TB] FAIL fill_credit: got prdy=%b count=%0d expected 1/33", wr_prdy, fifo_count); end
    guard = 0;
    rd_prdy = 1'b1;
    while (fifo_count != 6'd0 && guard < 100) begin tick(); guard++; end
    checks++; if (fifo_count !== 6'd0) begin errors++; $display("[TB] FAIL fill_drain: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    int sent;
    int popped;
    int gaps;
    int cycles;
    int first;
    int sent_at_100;
    sent = 0; popped = 0; gaps = 0; cycles = 0; first = -1; sent_at_100 = 0;
    while (popped < 100 && cycles < 400) begin
      tick(); wr_pvld = (sent < 100); wr_pd = 256'(sent); rd_prdy = 1'b1; #1;
      if (wr_pvld && wr_prdy) sent++;
      if (rd_pvld) begin
        if (popped == 0) first = cycles;
        popped++;
      end else if (popped > 0) begin
        gaps++;
      end
      cycles++;
      if (cycles == 100) sent_at_100 = sent;
    end
    wr_pvld = 1'b0;
    checks++; if (popped != 100) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 100", popped); end
    checks++; if (gaps != 0) begin errors++; $display("[TB] FAIL stream_gaps: got %0d expected 0", gaps); end
    checks++; if (first != 3) begin errors++; $display("[TB] FAIL stream_latency: got %0d expected 3", first); end
    checks++; if (sent_at_100 != 100) begin errors++; $display("[TB] FAIL stream_accept: got %0d expected 100", sent_at_100); end
    tick(); #1;
    checks++; if (fifo_count !== 6'd0) begin errors++; $display("[TB] FAIL stream_drain: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_random_backpressure();
    int sent;
    int cycles;
    int maxcnt;
    int pops_start;
    int guard;
    sent = 0; cycles = 0; maxcnt = 0; guard = 0;
    pops_start = pops_total;
    while (sent < 1000 && cycles < 20000) begin
      tick();
      wr_pvld = ($urandom_range(0, 9) < 7);
      wr_pd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rd_prdy = 1'($urandom_range(0, 1));
      #1;
      if (wr_pvld && wr_prdy) sent++;
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
      cycles++;
    end
    tick(); wr_pvld = 1'b0; rd_prdy = 1'b1;
    while (fifo_count != 6'd0 && guard < 100) begin tick(); guard++; end
    tick();
    checks++; if (sent != 1000) begin errors++; $display("[TB] FAIL rand_sent: got %0d expected 1000", sent); end
    checks++; if (pops_total - pops_start != 1000) begin errors++; $display("[TB] FAIL rand_popped: got %0d expected 1000", pops_total - pops_start); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rand_leftover: got %0d expected 0", exp_q.size()); end
    checks++; if (maxcnt > 34) begin errors++; $display("[TB] FAIL rand_maxcount: got %0d expected <=34", maxcnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    int guard;
    n = 0; guard = 0;
    rd_prdy = 1'b0;
    while (n < 11 && guard < 100) begin
      tick(); wr_pvld = 1'b1; wr_pd = 256'(n + 'h2000); #1;
      if (wr_prdy) n++;
      guard++;
    end
    tick(); wr_pvld = 1'b0;
    repeat (4) tick();
    tick(); rd_prdy = 1'b1; #1;
    tick(); rd_prdy = 1'b0; #1;
    checks++; if (fifo_count !== 6'd10) begin errors++; $display("[TB] FAIL mid_precount: got %0d expected 10", fifo_count); end
    rstn = 1'b0; #1;
    exp_q.delete();
    checks++; if (wr_prdy !== 1'b1 || rd_pvld !== 1'b0 || rd_pd !== 256'd0) begin errors++; $display("[TB] FAIL mid_reset_out: got prdy=%b pvld=%b pd=%h expected 1/0/0", wr_prdy, rd_pvld, rd_pd); end
    checks++; if (ram_re !== 1'b0 || ram_we !== 1'b0 || fifo_count !== 6'd0) begin errors++; $display("[TB] FAIL mid_reset_ctl: got re=%b we=%b count=%0d expected 0/0/0", ram_re, ram_we, fifo_count); end
    tick(); tick();
    rstn = 1'b1;
    tick(); wr_pvld = 1'b1; wr_pd = 256'h1; rd_prdy = 1'b1;
    tick(); wr_pd = 256'h2;
    tick(); wr_pvld = 1'b0; wr_pd = '0; #1;
    guard = 0;
    while (!rd_pvld && guard < 10) begin tick(); guard++; end
    checks++; if (rd_pvld !== 1'b1 || rd_pd !== 256'h1) begin errors++; $display("[TB] FAIL mid_first_word: got pvld=%b pd=%h expected 1/1", rd_pvld, rd_pd); end
    repeat (4) tick();
    checks++; if (fifo_count !== 6'd0) begin errors++; $display("[TB] FAIL mid_drain: got %0d expected 0", fifo_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_push();
    test_fill();
    test_back_to_back();
    test_random_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
